// File: rtl/stats_sweeper_avlstrm_pkg.sv
// Shared stats types and constants used by the sweeper and its stream interface.
package stats_sweeper_avlstrm_pkg;

    localparam int unsigned ADDR_W           = 8;
    localparam int unsigned VAL_W            = 32;
    localparam int unsigned NUM_REG          = 255;
    localparam int unsigned DEFAULT_INTERVAL = 1000;

    localparam logic [ADDR_W-1:0] REG_NOTUSED = 8'hFF;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [VAL_W-1:0]  val;
    } stats_t;

endpackage

// File: rtl/avl_stream_if.sv
// Single-beat Avalon-ST link carrying one stats_t per beat.
interface avl_stream_if;
    import stats_sweeper_avlstrm_pkg::*;

    logic   valid;
    logic   ready;
    logic   sop;
    logic   eop;
    stats_t data;

    modport tx (output valid, output sop, output eop, output data, input ready);
    modport rx (input valid, input sop, input eop, input data, output ready);

endinterface

// File: rtl/stats_interval_timer.sv
// Reloading down-counter; tick is high for the one cycle the count sits at 1.
module stats_interval_timer #(
    parameter int unsigned INTERVAL_W = 24
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic                  reload,
    output logic                  tick
);

    logic [INTERVAL_W-1:0] count_q, count_d;

    assign tick = (count_q == INTERVAL_W'(1));

    // A count of 0 also reloads, so the first cycle out of reset picks up interval.
    always_comb begin
        count_d = count_q - INTERVAL_W'(1);
        if (reload || (count_q <= INTERVAL_W'(1))) begin
            count_d = interval;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stats_sweeper_avlstrm.sv
// Periodic/on-demand stats snapshot packer streaming non-empty entries over Avalon-ST.
// Define STATS_SWEEP_DELTA_EN to send only entries whose value changed since last sent.
module stats_sweeper_avlstrm
    import stats_sweeper_avlstrm_pkg::*;
#(
    parameter int unsigned NUM_STATS  = 4,
    parameter int unsigned INTERVAL_W = 24,
    parameter int unsigned ID         = 0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  stats_t                stats [NUM_STATS],
    input  logic [INTERVAL_W-1:0] interval,
    input  logic                  flush,
    output logic                  busy,
    output logic [15:0]           sweep_cnt,
    avl_stream_if.tx              stats_out
);

    localparam int unsigned IDX_W = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;

    typedef enum logic [1:0] {StIdle, StSnap, StSend} state_e;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      cnt_q, cnt_d;
    stats_t           shadow_q [NUM_STATS];

    logic   tick, trigger, start, snap;
    logic   skip, delta_skip, out_valid, hs, last_idx;
    stats_t cur;
    logic   unused_id;

    assign unused_id = ^ID;

    stats_interval_timer #(
        .INTERVAL_W (INTERVAL_W)
    ) u_timer (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .interval (interval),
        .reload   (start),
        .tick     (tick)
    );

    assign trigger   = tick | flush;
    assign start     = (state_q == StIdle) && (pending_q || trigger);
    assign cur       = shadow_q[idx_q];
    assign skip      = (cur.addr == REG_NOTUSED) || delta_skip;
    assign out_valid = (state_q == StSend) && !skip;
    assign hs        = out_valid && stats_out.ready;
    assign last_idx  = (idx_q == IDX_W'(NUM_STATS - 1));

    assign busy            = (state_q != StIdle);
    assign sweep_cnt       = cnt_q;
    assign stats_out.valid = out_valid;
    assign stats_out.sop   = out_valid;
    assign stats_out.eop   = out_valid;
    assign stats_out.data  = out_valid ? cur : '0;

    always_comb begin
        state_d   = state_q;
        pending_d = (pending_q | trigger) & ~start;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        snap      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSnap;
            end
            StSnap: begin
                snap    = 1'b1;
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (skip || hs) begin
                    if (last_idx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        cnt_d   = cnt_q + 16'd1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < NUM_STATS; i++) shadow_q[i] <= '0;
        end else if (snap) begin
            shadow_q <= stats;
        end
    end

`ifdef STATS_SWEEP_DELTA_EN
    logic [VAL_W-1:0]     last_val_q [NUM_STATS];
    logic [NUM_STATS-1:0] sent_q;
    logic                 full_q, flush_pend_q;

    // A flush anywhere before the sweep starts makes that sweep ignore history.
    assign delta_skip = !full_q && sent_q[idx_q] && (cur.val == last_val_q[idx_q]);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < NUM_STATS; i++) last_val_q[i] <= '0;
            sent_q       <= '0;
            full_q       <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (start) begin
                full_q       <= flush_pend_q | flush;
                flush_pend_q <= 1'b0;
            end else if (flush) begin
                flush_pend_q <= 1'b1;
            end
            if (hs) begin
                last_val_q[idx_q] <= cur.val;
                sent_q[idx_q]     <= 1'b1;
            end
        end
    end
`else
    assign delta_skip = 1'b0;
`endif

endmodule

// File: tb/tb_stats_sweeper_avlstrm.sv
// Table-driven bench for stats_sweeper_avlstrm with hand sequences for flush/reset cases.
module tb_stats_sweeper_avlstrm;
    import stats_sweeper_avlstrm_pkg::*;

    localparam int unsigned N = 4;

    typedef struct {
        logic        ready;
        logic        flush;
        logic        chg;
        logic        exp_valid;
        logic        exp_busy;
        logic [7:0]  exp_addr;
        logic [31:0] exp_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [23:0] interval;
    logic        busy;
    logic [15:0] sweep_cnt;
    stats_t      stats [N];

    avl_stream_if sif ();

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stats_sweeper_avlstrm #(
        .NUM_STATS  (N),
        .INTERVAL_W (24),
        .ID         (0)
    ) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .stats     (stats),
        .interval  (interval),
        .flush     (flush),
        .busy      (busy),
        .sweep_cnt (sweep_cnt),
        .stats_out (sif)
    );

    function automatic vec_t mk(input logic rdy, input logic fl, input logic ch, input logic v,
                                input logic b, input logic [7:0] a, input logic [31:0] val);
        vec_t r;
        r.ready = rdy; r.flush = fl; r.chg = ch;
        r.exp_valid = v; r.exp_busy = b; r.exp_addr = a; r.exp_val = val;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vals(input int k);
        for (int i = 0; i < N; i++) stats[i].val = 32'(10 * (i + 1) + k);
    endtask

    task automatic run_seg(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            sif.ready = tbl[i].ready;
            flush     = tbl[i].flush;
            if (tbl[i].chg) stats[1].val = 32'd9;
            #1;
            check($sformatf("row%0d_valid", i), sif.valid, tbl[i].exp_valid);
            check($sformatf("row%0d_busy", i), busy, tbl[i].exp_busy);
            if (tbl[i].exp_valid) begin
                check($sformatf("row%0d_addr", i), sif.data.addr, tbl[i].exp_addr);
                check($sformatf("row%0d_val", i), sif.data.val, tbl[i].exp_val);
                check($sformatf("row%0d_sop_eop", i), {sif.sop, sif.eop}, 2'b11);
            end
        end
    endtask

    task automatic wait_busy(input int lim, output int at);
        int k;
        k  = 0;
        at = -1;
        while (at < 0 && k < lim) begin
            @(negedge clk);
            #1;
            k++;
            if (busy) at = cyc;
        end
        check("wait_busy_seen", (at >= 0), 1'b1);
    endtask

    task automatic collect(input int b0, input logic [31:0] s0,
                           output int beats, output logic [31:0] sig);
        int   k;
        logic done;
        k = 0; done = 1'b0; beats = b0; sig = s0;
        while (!done && k < 40) begin
            @(negedge clk);
            #1;
            k++;
            if (!busy) done = 1'b1;
            else if (sif.valid && sif.ready) begin
                beats++;
                sig = {sig[27:0], sif.data.addr[3:0]};
            end
        end
        check("sweep_ends", done, 1'b1);
    endtask

    task automatic flush_sweep(input int exp_beats, input logic [31:0] exp_sig);
        int          beats;
        logic [31:0] sig;
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("fl_idle_busy", busy, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_snap_busy", busy, 1'b1);
        check("fl_snap_valid", sif.valid, 1'b0);
        @(negedge clk);
        #1;
        check("fl_first_valid", sif.valid, 1'b1);
        check("fl_first_addr", sif.data.addr, 8'd1);
        collect(sif.valid ? 1 : 0, {28'd0, sif.data.addr[3:0]}, beats, sig);
        check("fl_beats", beats, exp_beats);
        check("fl_sig", sig, exp_sig);
    endtask

    initial begin
        int          t1, t2, t3, t4, sa, sb, sc, sd, se, beats, busy_seen;
        logic [31:0] sig;

        interval  = 24'd20;
        sif.ready = 1'b1;
        for (int i = 0; i < N; i++) stats[i].addr = 8'(i + 1);
        set_vals(0);

        // Sweep 1 and 2: plain bursts.
        sa = tbl.size();
        for (int i = 0; i < N; i++) tbl.push_back(mk(1, 0, 0, 1, 1, 8'(i + 1), 32'(10 * (i + 1))));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        sb = tbl.size();
        for (int i = 0; i < N; i++)
            tbl.push_back(mk(1, 0, 0, 1, 1, 8'(i + 1), 32'(10 * (i + 1) + 1)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        // Sweep 3: index 2 unused, one idle slot.
        sc = tbl.size();
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd1, 32'd12));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd2, 32'd22));
        tbl.push_back(mk(1, 0, 0, 0, 1, 8'd0, 32'd0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd4, 32'd42));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        // Sweep 4: stall on beat 1, live value changes, flush during stall.
        sd = tbl.size();
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd1, 32'd13));
        for (int k = 0; k < 10; k++) tbl.push_back(mk(0, k == 5, k == 3, 1, 1, 8'd2, 32'd5));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd2, 32'd5));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd3, 32'd33));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd4, 32'd43));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd1, 32'd13));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd2, 32'd9));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd3, 32'd33));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'd4, 32'd43));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        se = tbl.size();

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", sif.valid, 1'b0);
        check("rst_sop_eop", {sif.sop, sif.eop}, 2'b00);
        check("rst_data", sif.data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", sweep_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_busy(60, t1);
        run_seg(sa, sb - 1);
        check("cnt_after_1", sweep_cnt, 16'd1);

        set_vals(1);
        wait_busy(30, t2);
        check("period_1_2", t2 - t1, 20);
        run_seg(sb, sc - 1);
        check("cnt_after_2", sweep_cnt, 16'd2);

        set_vals(2);
        stats[2].addr = REG_NOTUSED;
        wait_busy(30, t3);
        check("period_2_3", t3 - t2, 20);
        run_seg(sc, sd - 1);
        check("cnt_after_3", sweep_cnt, 16'd3);

        stats[2].addr = 8'd3;
        set_vals(3);
        stats[1].val = 32'd5;
        wait_busy(30, t4);
        check("period_3_4", t4 - t3, 20);
        run_seg(sd, se - 1);
        check("cnt_after_flush_extra", sweep_cnt, 16'd5);

        // Flush-only operation.
        interval = 24'd0;
        flush_sweep(4, 32'h1234);
        check("cnt_fl1", sweep_cnt, 16'd6);
        beats = 0;
        busy_seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (sif.valid) beats++;
            if (busy) busy_seen++;
        end
        check("idle_beats", beats, 0);
        check("idle_busy", busy_seen, 0);
        flush_sweep(4, 32'h1234);
        check("cnt_fl2", sweep_cnt, 16'd7);

        // Reset during beat 2.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_valid", sif.valid, 1'b1);
        check("mid_addr", sif.data.addr, 8'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", sif.valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_cnt", sweep_cnt, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flush_sweep(4, 32'h1234);
        check("cnt_post_rst", sweep_cnt, 16'd1);

`ifdef STATS_SWEEP_DELTA_EN
        interval = 24'd20;
        wait_busy(60, t1);
        collect(0, 32'd0, beats, sig);
        check("delta_unchanged_beats", beats, 0);
        stats[3].val = 32'd77;
        wait_busy(30, t2);
        collect(0, 32'd0, beats, sig);
        check("delta_one_beats", beats, 1);
        check("delta_one_addr", sig, 32'h4);
        flush_sweep(4, 32'h1234);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stats_sweeper_avlstrm.md
# stats_sweeper_avlstrm

Parametrised periodic statistics packer. It takes a consistent snapshot of `NUM_STATS` `stats_t` entries on a programmable interval or on demand, then streams the non-empty entries as single-beat packets on an Avalon-ST transmit interface toward the stats unpacker/register file. It generalises the fixed-interval packer with these additions:
- runtime interval and flush trigger;
- atomic snapshot;
- pending-trigger coalescing;
- an optional change-only (delta) mode.

## Interface
Parameters:
- `NUM_STATS`, 4, number of stat entries swept (≥1).
- `INTERVAL_W`, 24, width of the interval timer.
- `ID`, 0, instance tag; informational only, no functional effect.

Ports:
- `Clk`  in  1  single clock.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `stats`  in  `stats_t[NUM_STATS]`  live stat entries (addr, val).
- `interval`  in  `INTERVAL_W`  cycles between sweep triggers; 0 disables periodic triggers.
- `flush`  in  1  single-cycle request for an immediate sweep.
- `busy`  out  1  high while in SNAP or SEND.
- `sweep_cnt`  out  16  count of completed sweeps; wraps.
- `stats_out`  `avl_stream_if.tx`  one `stats_t` per beat; sop=eop=valid.

## Operation
- The FSM has three states: IDLE, SNAP, SEND.
- **Trigger:** in any state, the interval timer reaching 1, or `flush`=1, sets `pending`. Multiple triggers before service coalesce into one.
- **IDLE → SNAP:** taken when `pending`=1. On entry, clear `pending` and reload the timer with `interval`.
- **SNAP:**
  - Copy all `stats[]` into a shadow bank in one cycle.
  - Set index `idx`=0.
  - Go to SEND.
- **SEND, per index, ascending from 0:**
  - If `shadow[idx].addr`==`REG_NOTUSED`, the entry is skipped: one cycle with valid=0.
  - Otherwise drive valid=sop=eop=1 with data=`shadow[idx]`. Hold data stable until ready=1.
  - On handshake or skip, `idx` increments.
  - After `idx`==`NUM_STATS`-1 completes, go to IDLE and increment `sweep_cnt`.
- **Timer:** counts down in every state and reloads with `interval` when it reaches 1. When `interval`==0 the timer is held at 0 and only `flush` triggers.
- **Interval change:** a change to `interval` takes effect at the next reload.
- **Trigger during SEND:** the current sweep completes unchanged, then a new sweep starts (the FSM passes through IDLE for one cycle).
- **Live inputs:** `stats` changing during SEND has no effect on emitted data, because the shadow bank holds the snapshot.
- **Reset mid-sweep:** the sweep is abandoned immediately; no partial-packet recovery is required.

## Timing
- Reset values:
  - FSM=IDLE, `pending`=0, timer=0, `idx`=0, `sweep_cnt`=0, `busy`=0.
  - `stats_out` valid/sop/eop=0, data=0.
- **First sweep after reset:** the timer loads `interval` on the first cycle out of reset.
- **Latency:** with the trigger at cycle t, SNAP occurs at t+1 and the first beat is valid at t+2.
- **Throughput:** one beat per cycle while ready=1; one cycle per skipped entry.
- **Sweep length:** with ready=1 throughout, a sweep occupies exactly `NUM_STATS`+1 cycles (SNAP plus `NUM_STATS`) in SNAP/SEND, followed by one cycle in IDLE before the next sweep can start.
- **Handshake rules:** valid never deasserts without a handshake; data is stable while valid=1 and ready=0.

## Configuration
- `STATS_SWEEP_DELTA_EN` defined:
  - Keep a `last_val` register and a `sent` flag per entry, both cleared by reset.
  - In SEND, an entry is also skipped if `sent`=1 and `shadow.val`==`last_val`.
  - On handshake, update `last_val` and set `sent`.
  - `flush` forces a full sweep: no delta skipping for that sweep.
- Macro undefined: every non-`REG_NOTUSED` entry is sent on every sweep, and no per-entry history registers exist.

## Structure
- `stats_t`, `REG_NOTUSED`, `NUM_REG`, and the default interval constant stay in the shared stats package (struct_s/stats_reg). The module declares no new typedefs.
- The FSM state enum is local to the module.
- Sub-module `stats_interval_timer` holds the reload counter and produces a 1-cycle `tick`; it takes `Clk`, `Rst_n`, and `interval`.

## Test plan
- **Basic periodic sweep:** `NUM_STATS`=4, `interval`=20, ready=1, addrs {1,2,3,4} → a burst of 4 beats in addr order 1,2,3,4 (starting 2 cycles after each trigger), one burst every 20 cycles; `sweep_cnt` increments once per burst.
- **NOTUSED skip:** entry 2 addr=`REG_NOTUSED` → 3 beats (addrs 1,2,4 at indices 0,1,3), with a 1-cycle valid gap at index 2.
- **Backpressure and snapshot:**
  - Setup: ready=0 for 10 cycles mid-sweep while `stats[1].val` changes from 5 to 9.
  - Required: data held stable and beat 1 carries val 5.
  - Required: a flush during the stall produces exactly one extra sweep, carrying val 9.
- **Flush-only mode:** `interval`=0, no `flush` for 100 cycles → no beats; a single `flush` pulse → one sweep, first valid 2 cycles later.
- **Reset mid-sweep:** `Rst_n` asserted during beat 2 → valid=0 asynchronously, `sweep_cnt`=0; the next sweep after release starts from index 0.
- **Delta mode (`STATS_SWEEP_DELTA_EN`):**
  - Two sweeps with unchanged values → the second emits 0 beats.
  - Change `stats[3].val` → the next sweep emits only addr 4.
  - `flush` → all 4 entries emitted.
